// File: rtl/spi_pkg.sv
// Shared types for the SPI flash engine and the command arbiter in front of it.
package spi_pkg;

    localparam int ADDR_W = 24;
    localparam int DATA_W = 8;

    // Command set understood by spi_control; NONE means "no operation requested".
    typedef enum logic [2:0] {
        NONE  = 3'd0,
        READ  = 3'd1,
        WRITE = 3'd2,
        ERASE = 3'd3,
        END   = 3'd4
    } cmd_t;

    // Arbiter FSM states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        HALT  = 2'd3
    } arb_state_t;

    // A request only competes for the engine when it actually carries a command.
    function automatic logic is_live_cmd(input cmd_t c);
        return (c != NONE);
    endfunction

endpackage

// File: rtl/spi_cmd_arbiter_rr.sv
// Combinational round-robin picker: searches from ptr+1 (mod N) upward and
// returns the first asserted request as both an index and a one-hot vector.
module rr_arbiter #(
    parameter int N  = 2,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);

    // Candidate k is the k-th position after the pointer, wrapping at N.
    logic [IW-1:0] w_cand [N];

    genvar gi;
    generate
        for (gi = 0; gi < N; gi++) begin : g_cand
            assign w_cand[gi] = IW'((32'(i_ptr) + 32'(gi) + 32'd1) % N);
        end
    endgenerate

    // Scan candidates from farthest to nearest so the nearest valid one wins last.
    always_comb begin
        o_valid = 1'b0;
        o_idx   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (i_req[w_cand[k]]) begin
                o_valid = 1'b1;
                o_idx   = w_cand[k];
            end
        end
    end

    generate
        for (gi = 0; gi < N; gi++) begin : g_onehot
            assign o_onehot[gi] = o_valid && (o_idx == IW'(gi));
        end
    endgenerate

endmodule

// File: rtl/spi_cmd_arbiter.sv
// Shares one spi_control engine between N_REQ requesters. A winner is picked
// round-robin, its command/address are latched and held for the whole
// operation, its write byte is muxed to the engine, and it gets a single-cycle
// done pulse on completion. An END command parks the arbiter until reset.
module spi_cmd_arbiter
    import spi_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic [N_REQ-1:0]  req,
    input  cmd_t              req_cmd   [N_REQ],
    input  logic [ADDR_W-1:0] req_addr  [N_REQ],
    input  logic [DATA_W-1:0] req_wdata [N_REQ],
    output logic [N_REQ-1:0]  gnt,
    output logic [N_REQ-1:0]  done,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              halted,
    output cmd_t              spi_cmd,
    output logic [ADDR_W-1:0] spi_addr_in,
    output logic [DATA_W-1:0] spi_data_in,
    input  logic              spi_cmd_done,
    input  logic [ADDR_W-1:0] spi_addr_out,
    input  logic [DATA_W-1:0] spi_data_out,
    input  logic              spi_f_done
);

    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    arb_state_t        r_state, r_state_next;
    cmd_t              r_spi_cmd, r_spi_cmd_next;
    logic [ADDR_W-1:0] r_spi_addr, r_spi_addr_next;
    logic [N_REQ-1:0]  r_gnt, r_gnt_next;
    logic [N_REQ-1:0]  r_done, r_done_next;
    logic              r_halted, r_halted_next;
    logic [IDX_W-1:0]  r_owner, r_owner_next;
    logic [IDX_W-1:0]  r_ptr, r_ptr_next;

    logic [N_REQ-1:0]  w_valid;
    logic [N_REQ-1:0]  w_win_onehot;
    logic [IDX_W-1:0]  w_win_idx;
    logic              w_win_valid;

    // A request asking for NONE never competes.
    genvar gi;
    generate
        for (gi = 0; gi < N_REQ; gi++) begin : g_valid
            assign w_valid[gi] = req[gi] && is_live_cmd(req_cmd[gi]);
        end
    endgenerate

    rr_arbiter #(
        .N  (N_REQ),
        .IW (IDX_W)
    ) u_rr (
        .i_req    (w_valid),
        .i_ptr    (r_ptr),
        .o_onehot (w_win_onehot),
        .o_idx    (w_win_idx),
        .o_valid  (w_win_valid)
    );

    // State and output registers; reset puts req 0 first in the rotation.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state    <= IDLE;
            r_spi_cmd  <= NONE;
            r_spi_addr <= '0;
            r_gnt      <= '0;
            r_done     <= '0;
            r_halted   <= 1'b0;
            r_owner    <= '0;
            r_ptr      <= IDX_W'(N_REQ - 1);
        end else begin
            r_state    <= r_state_next;
            r_spi_cmd  <= r_spi_cmd_next;
            r_spi_addr <= r_spi_addr_next;
            r_gnt      <= r_gnt_next;
            r_done     <= r_done_next;
            r_halted   <= r_halted_next;
            r_owner    <= r_owner_next;
            r_ptr      <= r_ptr_next;
        end
    end

    // Next-state logic: grant, wait for the engine to start, wait for it to finish.
    always_comb begin
        r_state_next    = r_state;
        r_spi_cmd_next  = r_spi_cmd;
        r_spi_addr_next = r_spi_addr;
        r_gnt_next      = r_gnt;
        r_done_next     = '0;
        r_halted_next   = r_halted;
        r_owner_next    = r_owner;
        r_ptr_next      = r_ptr;

        case (r_state)
            IDLE: begin
                if (w_win_valid && spi_cmd_done) begin
                    r_spi_cmd_next  = req_cmd[w_win_idx];
                    r_spi_addr_next = req_addr[w_win_idx];
                    r_gnt_next      = w_win_onehot;
                    r_owner_next    = w_win_idx;
                    r_ptr_next      = w_win_idx;
                    r_state_next    = ISSUE;
                end
            end
            ISSUE: begin
                // END never returns the engine to idle; completion is signalled by f_done.
                if (r_spi_cmd == END) begin
                    if (spi_f_done) begin
                        r_done_next   = r_gnt;
                        r_halted_next = 1'b1;
                        r_gnt_next    = '0;
                        r_state_next  = HALT;
                    end
                end else if (!spi_cmd_done) begin
                    r_state_next = BUSY;
                end
            end
            BUSY: begin
                // Dropping cmd on this edge beats the engine's next negedge sample,
                // so the same command cannot be started twice.
                if (spi_cmd_done) begin
                    r_spi_cmd_next = NONE;
                    r_gnt_next     = '0;
                    r_done_next    = r_gnt;
                    r_state_next   = IDLE;
                end
            end
            HALT: begin
                r_state_next = HALT;
            end
            default: begin
                r_state_next   = IDLE;
                r_spi_cmd_next = NONE;
                r_gnt_next     = '0;
            end
        endcase
    end

    assign gnt         = r_gnt;
    assign done        = r_done;
    assign halted      = r_halted;
    assign spi_cmd     = r_spi_cmd;
    assign spi_addr_in = r_spi_addr;
    assign spi_data_in = req_wdata[r_owner];
    assign rd_data     = spi_data_out;
    assign rd_addr     = spi_addr_out;

endmodule

// File: tb/tb_spi_cmd_arbiter.sv
// Directed bench for spi_cmd_arbiter with a small behavioural spi_control model.
module tb_spi_cmd_arbiter;
    import spi_pkg::*;

    localparam int N = 2;

    logic              clk;
    logic              n_rst;
    logic [N-1:0]      req;
    cmd_t              req_cmd   [N];
    logic [23:0]       req_addr  [N];
    logic [7:0]        req_wdata [N];
    logic [N-1:0]      gnt;
    logic [N-1:0]      done;
    logic [7:0]        rd_data;
    logic [23:0]       rd_addr;
    logic              halted;
    cmd_t              spi_cmd;
    logic [23:0]       spi_addr_in;
    logic [7:0]        spi_data_in;

    // flash engine model signals
    logic              m_cmd_done;
    logic              m_f_done;
    logic [23:0]       m_addr_out;
    logic [7:0]        m_data_out;
    logic              m_busy;
    cmd_t              m_op;
    logic [23:0]       m_addr;
    int                m_cnt;
    logic [7:0]        mem [256];

    int                n_cmp = 0;
    int                n_mis = 0;
    int                done_cnt [N];
    int                gnt_q [$];
    cmd_t              grant_cmd;
    logic [N-1:0]      prev_gnt;
    int                cs_low_seen;

    spi_cmd_arbiter #(.N_REQ(N)) dut (
        .clk          (clk),
        .n_rst        (n_rst),
        .req          (req),
        .req_cmd      (req_cmd),
        .req_addr     (req_addr),
        .req_wdata    (req_wdata),
        .gnt          (gnt),
        .done         (done),
        .rd_data      (rd_data),
        .rd_addr      (rd_addr),
        .halted       (halted),
        .spi_cmd      (spi_cmd),
        .spi_addr_in  (spi_addr_in),
        .spi_data_in  (spi_data_in),
        .spi_cmd_done (m_cmd_done),
        .spi_addr_out (m_addr_out),
        .spi_data_out (m_data_out),
        .spi_f_done   (m_f_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int op_len(input cmd_t c);
        case (c)
            READ:    return 3;
            WRITE:   return 4;
            ERASE:   return 8;
            default: return 3;
        endcase
    endfunction

    // Engine model: samples cmd on negedge while idle, completes after op_len cycles.
    always @(negedge clk) begin
        if (!n_rst) begin
            m_busy     <= 1'b0;
            m_cmd_done <= 1'b1;
            m_f_done   <= 1'b0;
            m_cnt      <= 0;
            m_op       <= NONE;
            m_addr     <= '0;
            m_addr_out <= '0;
            m_data_out <= '0;
            for (int i = 0; i < 256; i++) mem[i] <= 8'(i) ^ 8'hA5;
        end else if (m_busy) begin
            if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
            end else if (m_op == END) begin
                m_f_done <= 1'b1;
            end else begin
                m_busy     <= 1'b0;
                m_cmd_done <= 1'b1;
                case (m_op)
                    READ:  m_data_out <= mem[m_addr[7:0]];
                    WRITE: mem[m_addr[7:0]] <= spi_data_in;
                    ERASE: for (int i = 0; i < 16; i++) mem[{m_addr[7:4], 4'(i)}] <= 8'hFF;
                    default: ;
                endcase
            end
        end else if (spi_cmd != NONE) begin
            m_busy     <= 1'b1;
            m_cmd_done <= 1'b0;
            m_op       <= spi_cmd;
            m_addr     <= spi_addr_in;
            m_addr_out <= spi_addr_in;
            m_cnt      <= op_len(spi_cmd);
        end
    end

    // Records grant order, done pulses and engine activity; one line per transaction.
    always @(negedge clk) begin
        if (n_rst && gnt != 0 && prev_gnt == 0) begin
            for (int i = 0; i < N; i++) if (gnt[i]) gnt_q.push_back(i);
            grant_cmd = spi_cmd;
        end
        for (int i = 0; i < N; i++) begin
            if (done[i]) begin
                done_cnt[i]++;
                $display("txn req%0d op=%s rd_addr=%06h rd_data=%02h", i, grant_cmd.name(), rd_addr, rd_data);
            end
        end
        if (m_busy === 1'b1) cs_low_seen++;
        prev_gnt = n_rst ? gnt : '0;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_done(input int idx, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (done[idx]) begin
                hit = 1'b1;
                break;
            end
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic wait_gnt(input int idx, input int budget, input string tag);
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk); #1;
            if (gnt[idx]) begin
                hit = 1'b1;
                break;
            end
        end
        check(tag, 32'(hit), 32'd1);
    endtask

    task automatic do_reset();
        n_rst = 1'b0;
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b1;
    endtask

    initial begin
        int bad, nd, err, smp, base1, q0;
        n_rst = 1'b0;
        req   = '0;
        for (int i = 0; i < N; i++) begin
            req_cmd[i]   = NONE;
            req_addr[i]  = '0;
            req_wdata[i] = '0;
        end
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b1;

        // 1: reset values, quiet for 20 cycles, engine never selected
        check("rst_spi_cmd", 32'(spi_cmd), 32'(NONE));
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_spi_addr_in", spi_addr_in, 32'd0);
        cs_low_seen = 0;
        bad = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (spi_cmd != NONE || gnt != 0 || halted || done != 0) bad++;
        end
        check("t1_idle_bad_cycles", bad, 0);
        check("t1_cs_low_cycles", cs_low_seen, 0);

        // 2: single READ from req0
        req_cmd[0] = READ; req_addr[0] = 24'h000080; req[0] = 1'b1;
        @(negedge clk); #1;
        check("t2_gnt_latency", 32'(gnt), 32'd1);
        check("t2_spi_addr_in", spi_addr_in, 32'h80);
        check("t2_spi_cmd", 32'(spi_cmd), 32'(READ));
        wait_done(0, 50, "t2_done_seen");
        req[0] = 1'b0;
        check("t2_cmd_none_at_done", 32'(spi_cmd), 32'(NONE));
        check("t2_rd_data", 32'(rd_data), 32'h25);
        check("t2_rd_addr", rd_addr, 32'h80);
        repeat (5) @(negedge clk);
        check("t2_done_once", done_cnt[0], 1);

        // 3: two writers held continuously alternate
        do_reset();
        gnt_q.delete();
        req_cmd[0] = WRITE; req_addr[0] = 24'h000010; req_wdata[0] = 8'hFE;
        req_cmd[1] = WRITE; req_addr[1] = 24'h000020; req_wdata[1] = 8'h5A;
        req = 2'b11;
        nd = 0; err = 0; smp = 0;
        for (int c = 0; c < 400 && nd < 4; c++) begin
            @(negedge clk); #1;
            if (gnt == 2'b01) begin smp++; if (spi_data_in != 8'hFE) err++; end
            if (gnt == 2'b10) begin smp++; if (spi_data_in != 8'h5A) err++; end
            if (done != 0) nd++;
        end
        req = 2'b00;
        check("t3_done_count", nd, 4);
        check("t3_grant_count", gnt_q.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t3_order%0d", i), gnt_q[i], i % 2);
        check("t3_wdata_mux_errors", err, 0);
        check("t3_wdata_sampled", 32'(smp > 0), 32'd1);
        check("t3_mem_10", 32'(mem[8'h10]), 32'hFE);
        check("t3_mem_20", 32'(mem[8'h20]), 32'h5A);

        // 4: ERASE with request dropped mid-operation
        base1 = done_cnt[1];
        q0 = gnt_q.size();
        req_cmd[1] = ERASE; req_addr[1] = 24'h000020; req[1] = 1'b1;
        wait_gnt(1, 20, "t4_gnt_seen");
        repeat (3) @(negedge clk);
        #1 req[1] = 1'b0;
        wait_done(1, 50, "t4_done_seen");
        repeat (20) @(negedge clk);
        check("t4_done_once", done_cnt[1], base1 + 1);
        check("t4_single_grant", gnt_q.size(), q0 + 1);
        check("t4_mem_20", 32'(mem[8'h20]), 32'hFF);
        check("t4_mem_2f", 32'(mem[8'h2F]), 32'hFF);
        check("t4_mem_10", 32'(mem[8'h10]), 32'hFE);

        // 5: END halts the arbiter for good
        req_cmd[0] = END; req_addr[0] = 24'h0; req[0] = 1'b1;
        wait_done(0, 50, "t5_done_seen");
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_gnt_cleared", 32'(gnt), 32'd0);
        check("t5_cmd_stays_end", 32'(spi_cmd), 32'(END));
        req[0] = 1'b0;
        req_cmd[1] = READ; req_addr[1] = 24'h000040; req[1] = 1'b1;
        q0 = gnt_q.size();
        bad = 0;
        repeat (20) begin
            @(negedge clk); #1;
            if (gnt != 0) bad++;
        end
        check("t5_no_grant_after_halt", bad, 0);
        check("t5_grant_count_frozen", gnt_q.size(), q0);
        check("t5_still_halted", 32'(halted), 32'd1);
        req[1] = 1'b0;

        // 6: asynchronous reset in the middle of a WRITE
        do_reset();
        req_cmd[0] = WRITE; req_addr[0] = 24'h000030; req_wdata[0] = 8'h77; req[0] = 1'b1;
        wait_gnt(0, 20, "t6_gnt_seen");
        repeat (2) @(negedge clk);
        #2 n_rst = 1'b0;
        req[0] = 1'b0;
        #1;
        check("t6_rst_spi_cmd", 32'(spi_cmd), 32'(NONE));
        check("t6_rst_gnt", 32'(gnt), 32'd0);
        check("t6_rst_addr", spi_addr_in, 32'd0);
        check("t6_rst_halted", 32'(halted), 32'd0);
        check("t6_rst_done", 32'(done), 32'd0);
        repeat (3) @(negedge clk);
        #1 n_rst = 1'b1;
        req_cmd[0] = READ; req_addr[0] = 24'h000030; req[0] = 1'b1;
        wait_done(0, 50, "t6_read_done_seen");
        req[0] = 1'b0;
        check("t6_rd_data", 32'(rd_data), 32'h95);
        repeat (3) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
